// File: rtl/program_loader_if.sv
// Boot-loader bus: UART byte stream in, instruction-memory write port and status out.
// The loader is the slave; the host side (UART receiver plus core control) is the master.
interface program_loader_if;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] words_loaded;

   modport master (
      output start, rx_data, rx_valid,
      input  wr_en, wr_addr, wr_data, busy, done, error, words_loaded
   );

   modport slave (
      input  start, rx_data, rx_valid,
      output wr_en, wr_addr, wr_data, busy, done, error, words_loaded
   );
endinterface

// File: rtl/program_loader.sv
// Boot-time program receiver: length-prefixed little-endian byte stream -> 32-bit imem writes.
// Oversized counts and stalled transfers end in a sticky error state instead of hanging.
module program_loader #(
   parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 16384,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input logic             clk,
   input logic             rstn,
   program_loader_if.slave bus
);
   typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [23:0] shift;
   logic [31:0] count;
   logic [31:0] tcnt;
   logic [31:0] full_word;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] words_loaded;

   // shift holds the three earlier bytes; the incoming byte completes the word
   assign full_word = {bus.rx_data, shift};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= IDLE;
         byte_cnt     <= 2'd0;
         shift        <= 24'd0;
         count        <= 32'd0;
         tcnt         <= 32'd0;
         wr_en        <= 1'b0;
         wr_addr      <= 32'd0;
         wr_data      <= 32'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= 32'd0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= HDR;
                  busy     <= 1'b1;
                  byte_cnt <= 2'd0;
                  tcnt     <= 32'd0;
               end
            end
            HDR, DATA: begin
               if (bus.rx_valid) begin
                  tcnt     <= 32'd0;
                  byte_cnt <= byte_cnt + 2'd1;
                  shift    <= {bus.rx_data, shift[23:8]};
                  if (byte_cnt == 2'd3) begin
                     if (state == HDR) begin
                        count <= full_word;
                        if (full_word == 32'd0) begin
                           state <= DONE;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end else if (full_word > 32'(MAX_WORDS)) begin
                           state <= ERR;
                           busy  <= 1'b0;
                           error <= 1'b1;
                        end else begin
                           state <= DATA;
                        end
                     end else begin
                        wr_en        <= 1'b1;
                        wr_data      <= full_word;
                        wr_addr      <= ADDR_BASE + (words_loaded << 2);
                        words_loaded <= words_loaded + 32'd1;
                     end
                  end
               end else if (tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
                  state <= ERR;
                  busy  <= 1'b0;
                  error <= 1'b1;
               end else begin
                  tcnt <= tcnt + 32'd1;
               end
               // words_loaded already reflects the write on the wr_en cycle, so done lands one later
               if (state == DATA && wr_en && words_loaded == count) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  error <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done <= 1'b1;
            end
            ERR: begin
               error <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wr_en        = wr_en;
   assign bus.wr_addr      = wr_addr;
   assign bus.wr_data      = wr_data;
   assign bus.busy         = busy;
   assign bus.done         = done;
   assign bus.error        = error;
   assign bus.words_loaded = words_loaded;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected imem writes are queued as words are sent
// and matched (address, data, cycle of arrival) whenever wr_en is observed.
module tb_program_loader;
   localparam logic [31:0] ADDR_BASE      = 32'h0000_0000;
   localparam int unsigned MAX_WORDS      = 16;
   localparam int unsigned TIMEOUT_CYCLES = 100;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   exp_idx = 0;
   wr_t  sb[$];

   program_loader_if bus ();

   program_loader #(
      .ADDR_BASE      (ADDR_BASE),
      .MAX_WORDS      (MAX_WORDS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Every write must match the oldest queued word, arriving one cycle after its last byte
   always @(negedge clk) begin
      if (bus.wr_en) begin
         if (sb.size() == 0) begin
            check("wr_unexpected", {31'd0, bus.wr_en}, 32'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", bus.wr_addr, e.addr);
            check("wr_data", bus.wr_data, e.data);
            check("wr_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit is_data);
      for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
      if (is_data) begin
         sb.push_back('{addr: ADDR_BASE + 32'(4 * exp_idx), data: w, cyc: cyc});
         exp_idx++;
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      bus.start    = 1'b0;
      bus.rx_valid = 1'b0;
      rstn         = 1'b0;
      tick();
      tick();
      check({tag, "_rst_outputs"},
            {26'd0, bus.wr_en, bus.busy, bus.done, bus.error, 2'd0}, 32'd0);
      check({tag, "_rst_words"}, bus.words_loaded, 32'd0);
      check({tag, "_rst_addr"}, bus.wr_addr, 32'd0);
      check({tag, "_rst_data"}, bus.wr_data, 32'd0);
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      sb.delete();
      exp_idx = 0;
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start    = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'd0;

      // Two-word load, the reference example
      do_reset("t1");
      pulse_start();
      check("t1_busy", {31'd0, bus.busy}, 32'd1);
      send_word(32'd2, 1'b0);
      send_word(32'h0000_0013, 1'b1);
      send_word(32'h0010_0093, 1'b1);
      check("t1_last_wr_en", {31'd0, bus.wr_en}, 32'd1);
      check("t1_done_not_yet", {31'd0, bus.done}, 32'd0);
      tick();
      check("t1_done", {31'd0, bus.done}, 32'd1);
      check("t1_busy_low", {31'd0, bus.busy}, 32'd0);
      check("t1_words", bus.words_loaded, 32'd2);
      check("t1_hold_addr", bus.wr_addr, 32'h4);
      check("t1_hold_data", bus.wr_data, 32'h0010_0093);
      pulse_start();
      for (int i = 0; i < 5; i++) send(8'hA5);
      check("t1_done_held", {31'd0, bus.done}, 32'd1);
      check("t1_words_held", bus.words_loaded, 32'd2);

      // Zero-length program
      do_reset("t2");
      pulse_start();
      for (int i = 0; i < 3; i++) send(8'h00);
      check("t2_done_early", {31'd0, bus.done}, 32'd0);
      send(8'h00);
      check("t2_done", {31'd0, bus.done}, 32'd1);
      check("t2_error", {31'd0, bus.error}, 32'd0);
      check("t2_words", bus.words_loaded, 32'd0);

      // Oversize header
      do_reset("t3");
      pulse_start();
      send_word(MAX_WORDS + 1, 1'b0);
      check("t3_error", {31'd0, bus.error}, 32'd1);
      check("t3_busy", {31'd0, bus.busy}, 32'd0);
      for (int i = 0; i < 8; i++) send(8'(i));
      check("t3_done", {31'd0, bus.done}, 32'd0);
      check("t3_words", bus.words_loaded, 32'd0);

      // Exactly MAX_WORDS is accepted
      do_reset("t3b");
      pulse_start();
      send_word(MAX_WORDS, 1'b0);
      check("t3b_error", {31'd0, bus.error}, 32'd0);
      check("t3b_busy", {31'd0, bus.busy}, 32'd1);

      // Timeout after a partial word
      do_reset("t4");
      pulse_start();
      send_word(32'd1, 1'b0);
      send(8'h11);
      send(8'h22);
      repeat (TIMEOUT_CYCLES - 1) tick();
      check("t4_error_early", {31'd0, bus.error}, 32'd0);
      tick();
      check("t4_error", {31'd0, bus.error}, 32'd1);
      check("t4_busy", {31'd0, bus.busy}, 32'd0);
      send(8'h33);
      send(8'h44);
      check("t4_words", bus.words_loaded, 32'd0);

      // Timeout while waiting for the first header byte
      do_reset("t4b");
      pulse_start();
      repeat (TIMEOUT_CYCLES - 1) tick();
      check("t4b_error_early", {31'd0, bus.error}, 32'd0);
      tick();
      check("t4b_error", {31'd0, bus.error}, 32'd1);

      // Back-to-back bytes for three words
      do_reset("t5");
      pulse_start();
      send_word(32'd3, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b1);
      send_word(32'h0123_4567, 1'b1);
      send_word(32'h89AB_CDEF, 1'b1);
      check("t5_done_not_yet", {31'd0, bus.done}, 32'd0);
      tick();
      check("t5_done", {31'd0, bus.done}, 32'd1);
      check("t5_words", bus.words_loaded, 32'd3);

      // Reset mid-load, then a fresh single-word load
      do_reset("t6");
      pulse_start();
      send_word(32'd2, 1'b0);
      send_word(32'hCAFE_F00D, 1'b1);
      send(8'h55);
      send(8'h66);
      do_reset("t6r");
      pulse_start();
      send_word(32'd1, 1'b0);
      send_word(32'h1234_5678, 1'b1);
      tick();
      check("t6_done", {31'd0, bus.done}, 32'd1);
      check("t6_words", bus.words_loaded, 32'd1);
      check("t6_addr", bus.wr_addr, ADDR_BASE);

      tick();
      check("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
